// File: rtl/circuito_exp4_desafio.sv
`default_nettype none
// ============================================================================
// Module      : circuito_exp4_desafio
// Description : Memory game. The player repeats a 16-entry one-hot ROM
//               sequence on four buttons, with a per-play timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module circuito_exp4_desafio #(
    parameter int TIMEOUT = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic       db_timeout,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    localparam int              C_TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_TW-1:0] C_TLAST = C_TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t         r_estado;
    estado_t         w_estado_next;
    logic [3:0]      r_endereco;
    logic [3:0]      r_jogada;
    logic [3:0]      r_dado;
    logic [C_TW-1:0] r_tempo;
    logic            r_jogada_ant;
    logic            r_tem_jogada;
    logic            r_acertou;
    logic            r_errou;
    logic            r_pronto;
    logic            r_timeout;
    logic            w_jogada;
    logic            w_igual;
    logic            w_fim_tempo;

    function automatic logic [3:0] rom(input logic [3:0] a);
        case (a)
            4'd0, 4'd6, 4'd7, 4'd14:          rom = 4'b0001;
            4'd1, 4'd5, 4'd8, 4'd9:           rom = 4'b0010;
            4'd2, 4'd4, 4'd10, 4'd11, 4'd15:  rom = 4'b0100;
            default:                          rom = 4'b1000;
        endcase
    endfunction

    // Active-low segments, bit order g..a
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_jogada    = |chaves;
    assign w_igual     = (r_jogada == r_dado);
    assign w_fim_tempo = (r_tempo == C_TLAST);

    // Datapath: ROM output is registered, so it trails the address by a cycle;
    // the FSM never compares within that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_endereco   <= 4'd0;
            r_jogada     <= 4'd0;
            r_dado       <= 4'd0;
            r_tempo      <= '0;
            r_jogada_ant <= 1'b0;
            r_tem_jogada <= 1'b0;
        end else begin
            r_jogada_ant <= w_jogada;
            r_tem_jogada <= w_jogada & ~r_jogada_ant;
            r_dado       <= rom(r_endereco);
            case (r_estado)
                PREPARACAO: begin
                    r_endereco <= 4'd0;
                    r_jogada   <= 4'd0;
                    r_tempo    <= '0;
                end
                ESPERA:   r_tempo  <= w_fim_tempo ? '0 : r_tempo + C_TW'(1);
                REGISTRA: r_jogada <= chaves;
                PROXIMO: begin
                    r_endereco <= r_endereco + 4'd1;
                    r_tempo    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_estado_next = INICIAL;
        case (r_estado)
            INICIAL:    w_estado_next = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: w_estado_next = ESPERA;
            ESPERA: begin
                if (r_tem_jogada)     w_estado_next = REGISTRA;
                else if (w_fim_tempo) w_estado_next = FIM_TIMEOUT;
                else                  w_estado_next = ESPERA;
            end
            REGISTRA:   w_estado_next = COMPARA;
            COMPARA: begin
                if (!w_igual)                 w_estado_next = FIM_ERRO;
                else if (r_endereco == 4'hF)  w_estado_next = FIM_ACERTO;
                else                          w_estado_next = PROXIMO;
            end
            PROXIMO:    w_estado_next = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                        w_estado_next = iniciar ? PREPARACAO : r_estado;
            default:    w_estado_next = INICIAL;
        endcase
    end

    // Flags are registered from the next state so they align with r_estado.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= INICIAL;
            r_acertou <= 1'b0;
            r_errou   <= 1'b0;
            r_pronto  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_estado  <= w_estado_next;
            r_acertou <= (w_estado_next == FIM_ACERTO);
            r_errou   <= (w_estado_next == FIM_ERRO) || (w_estado_next == FIM_TIMEOUT);
            r_pronto  <= (w_estado_next == FIM_ACERTO) || (w_estado_next == FIM_ERRO) ||
                         (w_estado_next == FIM_TIMEOUT);
            r_timeout <= (w_estado_next == FIM_TIMEOUT);
        end
    end

    assign acertou        = r_acertou;
    assign errou          = r_errou;
    assign pronto         = r_pronto;
    assign db_timeout     = r_timeout;
    assign leds           = r_jogada;
    assign db_igual       = w_igual;
    assign db_contagem    = hex7(r_endereco);
    assign db_memoria     = hex7(r_dado);
    assign db_estado      = hex7(r_estado);
    assign db_jogadafeita = hex7(r_jogada);
    assign db_clock       = clock;
    assign db_iniciar     = iniciar;
    assign db_tem_jogada  = r_tem_jogada;

endmodule
`default_nettype wire

// File: tb/tb_circuito_exp4_desafio.sv
`default_nettype none
// Testbench for circuito_exp4_desafio: random games scored against a
// game-level reference model through an expected-outcome queue.
module tb_circuito_exp4_desafio;

    localparam int TO = 40;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves  = 4'd0;
    logic       acertou, errou, pronto, db_igual, db_timeout;
    logic       db_clock, db_iniciar, db_tem_jogada;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

    always #5 clock = ~clock;

    circuito_exp4_desafio #(.TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .chaves         (chaves),
        .acertou        (acertou),
        .errou          (errou),
        .pronto         (pronto),
        .leds           (leds),
        .db_igual       (db_igual),
        .db_timeout     (db_timeout),
        .db_contagem    (db_contagem),
        .db_memoria     (db_memoria),
        .db_estado      (db_estado),
        .db_jogadafeita (db_jogadafeita),
        .db_clock       (db_clock),
        .db_iniciar     (db_iniciar),
        .db_tem_jogada  (db_tem_jogada)
    );

    int checks = 0;
    int passed = 0;

    // Expected sequence and active-high hex glyphs (inverted for the display).
    int         seq [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};
    logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] seg(input int v);
        return ~lit[v & 15];
    endfunction

    typedef struct {
        int code;
        int addr;
        int leds;
        int pulses;
    } game_t;

    game_t exp_q[$];
    game_t mon_g;
    int    pulses      = 0;
    logic  pronto_prev = 1'b0;

    function automatic game_t make_game(input int code, input int addr, input int l, input int p);
        game_t g;
        g.code   = code;
        g.addr   = addr;
        g.leds   = l;
        g.pulses = p;
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: counts play pulses and scores each finished game.
    always @(negedge clock) begin
        if (reset) begin
            pulses      = 0;
            pronto_prev = 1'b0;
        end else begin
            if (db_tem_jogada) pulses++;
            if (pronto && !pronto_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end", 32'd1, 32'd0);
                end else begin
                    mon_g = exp_q.pop_front();
                    check("end_state", db_estado, seg(mon_g.code));
                    check("end_addr", db_contagem, seg(mon_g.addr));
                    check("end_leds", leds, mon_g.leds);
                    check("end_play_seg", db_jogadafeita, seg(mon_g.leds));
                    check("end_flags", {acertou, errou, db_timeout},
                          {mon_g.code == 10, mon_g.code != 10, mon_g.code == 13});
                    check("play_pulses", pulses, mon_g.pulses);
                end
                pulses = 0;
            end
            pronto_prev = pronto;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, db_estado, seg(0));
        check({tag, "_addr"}, db_contagem, seg(0));
        check({tag, "_mem"}, db_memoria, seg(0));
        check({tag, "_play_seg"}, db_jogadafeita, seg(0));
        check({tag, "_leds"}, leds, 0);
        check({tag, "_flags"}, {pronto, acertou, errou, db_timeout}, 4'd0);
    endtask

    task automatic start_game(input int hold);
        iniciar = 1'b1;
        tick(hold);
        iniciar = 1'b0;
        tick(1);
        check("start_state", db_estado, seg(2));
        check("start_addr", db_contagem, seg(0));
    endtask

    task automatic press(input logic [3:0] v, input int gap);
        chaves = v;
        tick(10);
        chaves = 4'd0;
        tick(gap);
    endtask

    // n correct plays, then a win (n=16), a wrong play (kind 0) or a timeout.
    task automatic run_game(input int n, input int kind);
        logic [3:0] bad;
        if (n >= 16) begin
            exp_q.push_back(make_game(10, 15, seq[15], 16));
        end else if (kind == 0) begin
            do bad = 4'($urandom_range(1, 15)); while (int'(bad) == seq[n]);
            exp_q.push_back(make_game(14, n, int'(bad), n + 1));
        end else begin
            bad = 4'd0;
            exp_q.push_back(make_game(13, n, (n == 0) ? 0 : seq[n-1], n));
        end
        start_game(int'($urandom_range(1, 4)));
        tick(2);
        for (int i = 0; i < n && i < 16; i++) press(4'(seq[i]), int'($urandom_range(10, 14)));
        if (n < 16) begin
            if (kind == 0) press(bad, 12);
            else tick(TO + 10);
        end
    endtask

    int lat;

    initial begin
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(1);

        // Full winning game, started with a 5-cycle iniciar pulse.
        exp_q.push_back(make_game(10, 15, 4, 16));
        iniciar = 1'b1;
        #1 check("db_iniciar", db_iniciar, 1);
        tick(1);
        check("start5_s1", db_estado, seg(1));
        tick(1);
        check("start5_s2", db_estado, seg(2));
        tick(3);
        iniciar = 1'b0;
        check("start5_hold", db_estado, seg(2));
        check("start5_addr", db_contagem, seg(0));
        check("start5_mem", db_memoria, seg(1));
        for (int i = 0; i < 16; i++) press(4'(seq[i]), 10);

        // 0001, 0010, 1000: third play mismatches at address 2.
        exp_q.push_back(make_game(14, 2, 8, 3));
        start_game(1);
        press(4'b0001, 10);
        press(4'b0010, 10);
        press(4'b1000, 12);

        // No play at all: espera lasts exactly TO cycles.
        exp_q.push_back(make_game(13, 0, 0, 0));
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        lat = 0;
        for (int i = 1; i <= TO + 5; i++) begin
            tick(1);
            if (pronto) begin
                lat = i;
                break;
            end
        end
        check("timeout_cycles", lat - 1, TO);
        tick(3);

        for (int g = 0; g < 10; g++)
            run_game(int'($urandom_range(0, 16)), int'($urandom_range(0, 1)));

        // Reset in the middle of a game at address 5.
        start_game(2);
        for (int i = 0; i < 5; i++) press(4'(seq[i]), 10);
        check("midgame_addr", db_contagem, seg(5));
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        tick(1);
        reset = 1'b0;
        tick(1);
        run_game(3, 0);
        run_game(16, 0);

        tick(5);
        check("pending_games", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
